line_writeback_unit: RTL and testbench

//  Read side of the cache data array: on an eviction/flush request, captures one way's 256-bit line

---
 rtl/wb_pkg.sv | 18 +
 rtl/line_serializer.sv | 70 +++++++
 rtl/line_writeback_unit.sv | 116 +++++++++++
 tb/tb_line_writeback_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Package: wb_pkg
// Shared constants and FSM state encoding for the line writeback unit.
package wb_pkg;

  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 32;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  // log2(LINE_W/8): number of byte-offset bits inside one line
  localparam int LINE_OFF   = 5;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_SEND,
    WB_DONE
  } wb_state_e;

endpackage

// File: rtl/line_serializer.sv
// Module: line_serializer
// Holds the captured cache line and the beat counter, and presents the current
// beat word (plus its parity when WB_PARITY_EN is defined) as registered outputs.
module line_serializer
  import wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [LINE_W-1:0]     line_in,
  input  logic                  advance,
  output logic [BEAT_IDX_W-1:0] beat_idx,
  output logic [BEAT_W-1:0]     beat_data,
  output logic                  beat_par
);

  logic [LINE_W-1:0]     line_reg;
  logic [BEAT_IDX_W-1:0] idx_reg;
  logic [BEAT_IDX_W-1:0] idx_next;
  logic [BEAT_W-1:0]     data_reg;
  logic [BEAT_W-1:0]     words [BEATS];

  // Split the captured line into beat-sized words, word 0 in the LSBs
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_words
      assign words[gi] = line_reg[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  assign idx_next = idx_reg + 1'b1;

  // Capture the line on load (beat 0 presented at once), step one word per advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_reg <= '0;
      idx_reg  <= '0;
      data_reg <= '0;
    end else if (load) begin
      line_reg <= line_in;
      idx_reg  <= '0;
      data_reg <= line_in[BEAT_W-1:0];
    end else if (advance) begin
      idx_reg  <= idx_next;
      data_reg <= words[idx_next];
    end
  end

`ifdef WB_PARITY_EN
  logic par_reg;

  // Even parity registered alongside the beat word so it changes only with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_reg <= 1'b0;
    end else if (load) begin
      par_reg <= ^line_in[BEAT_W-1:0];
    end else if (advance) begin
      par_reg <= ^words[idx_next];
    end
  end

  assign beat_par = par_reg;
`else
  assign beat_par = 1'b0;
`endif

  assign beat_idx  = idx_reg;
  assign beat_data = data_reg;

endmodule

// File: rtl/line_writeback_unit.sv
// Module: line_writeback_unit
// Captures one way's line from the data-array block outputs on a request and
// streams it to memory as BEATS valid/ready beats with incrementing addresses.
// Optional: define WB_PARITY_EN to drive mem_parity with even parity of mem_data.
module line_writeback_unit
  import wb_pkg::*;
#(
  parameter int WAYS   = 8,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_way,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [WAYS*LINE_W-1:0] block_in,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [BEAT_W-1:0]      mem_data,
  output logic                   mem_last,
  output logic                   mem_parity,
  output logic                   done
);

  wb_state_e             state_reg;
  logic                  accept;
  logic                  advance;
  logic [LINE_W-1:0]     way_lines [WAYS];
  logic [LINE_W-1:0]     sel_line;
  logic [BEAT_IDX_W-1:0] beat_idx;
  logic                  unused_addr_bits;

  // Byte offset within the line is irrelevant: lines are always sent from their base
  assign unused_addr_bits = ^req_addr[LINE_OFF-1:0];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_ways
      assign way_lines[gi] = block_in[gi*LINE_W +: LINE_W];
    end
  endgenerate

  // Way select; an out-of-range way yields a defined all-zero line
  always_comb begin
    sel_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (req_way == 3'(w)) sel_line = way_lines[w];
    end
  end

  assign accept  = req_valid && req_ready;
  assign advance = mem_valid && mem_ready && !mem_last;

  line_serializer u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .line_in   (sel_line),
    .advance   (advance),
    .beat_idx  (beat_idx),
    .beat_data (mem_data),
    .beat_par  (mem_parity)
  );

  // Control FSM: request handshake, beat address/last generation, completion pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= WB_IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_last  <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
    end else begin
      case (state_reg)
        WB_IDLE: begin
          if (accept) begin
            state_reg <= WB_SEND;
            req_ready <= 1'b0;
            mem_valid <= 1'b1;
            mem_last  <= 1'b0;
            mem_addr  <= {req_addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
          end
        end
        WB_SEND: begin
          if (mem_ready) begin
            if (mem_last) begin
              state_reg <= WB_DONE;
              mem_valid <= 1'b0;
              mem_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              // Wraps modulo 2^ADDR_W by construction
              mem_addr <= mem_addr + ADDR_W'(BEAT_W / 8);
              mem_last <= (beat_idx == BEAT_IDX_W'(BEATS - 2));
            end
          end
        end
        WB_DONE: begin
          state_reg <= WB_IDLE;
          done      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state_reg <= WB_IDLE;
          req_ready <= 1'b1;
          mem_valid <= 1'b0;
          mem_last  <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_writeback_unit.sv
// Testbench: tb_line_writeback_unit
// Table-driven line requests, hand-written stall / overlap / reset sequences and
// randomized requests checked against a beat-level reference model.
module tb_line_writeback_unit;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [2:0]     req_way;
  logic [31:0]    req_addr;
  logic [2047:0]  block_in;
  logic           mem_valid;
  logic           mem_ready;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_data;
  logic           mem_last;
  logic           mem_parity;
  logic           done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  way;
    logic [31:0] addr;
    logic [15:0] hi;        // line word k = {hi, k}
    logic [31:0] exp_base;  // expected address of beat 0
  } vec_t;

  vec_t vt [4];

  always #5 clk = ~clk;

  line_writeback_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_way    (req_way),
    .req_addr   (req_addr),
    .block_in   (block_in),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_last   (mem_last),
    .mem_parity (mem_parity),
    .done       (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [15:0] hi);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = {hi, 16'(k)};
    return l;
  endfunction

  task automatic set_way(input int w, input logic [255:0] l);
    block_in[w*256 +: 256] = l;
  endtask

  task automatic fill_random_block();
    for (int i = 0; i < 64; i++) block_in[i*32 +: 32] = $urandom;
  endtask

  // Present a request for one cycle (or keep it asserted when hold is set)
  task automatic send_req(input logic [2:0] w, input logic [31:0] a, input bit hold);
    req_way   = w;
    req_addr  = a;
    req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // Reference model: beat k of a line has address base+4k (mod 2^32) and data
  // word k of the captured line; compare every cycle the beat is presented.
  task automatic stream(input logic [31:0] base, input logic [255:0] line,
                        input int stall_beat, input int stall_len, input bit rnd,
                        input int abort_at, input bit scramble);
    int k = 0;
    int stalled = 0;
    int cyc = 0;
    logic [31:0] ea, ed;
    logic ep;
    while (k < 8 && k != abort_at && cyc < 200) begin
      if (rnd) mem_ready = ($urandom_range(0, 9) < 7);
      else if (k == stall_beat && stalled < stall_len) begin
        mem_ready = 1'b0;
        stalled++;
      end else mem_ready = 1'b1;
      ea = base + 32'(4 * k);
      ed = line[k*32 +: 32];
`ifdef WB_PARITY_EN
      ep = ^ed;
`else
      ep = 1'b0;
`endif
      chk("beat_valid", mem_valid, 1);
      chk("beat_addr", mem_addr, ea);
      chk("beat_data", mem_data, ed);
      chk("beat_last", mem_last, (k == 7));
      chk("beat_parity", mem_parity, ep);
      chk("busy_done", done, 0);
      chk("busy_req_ready", req_ready, 0);
      if (scramble) fill_random_block();
      if (mem_valid && mem_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    if (k == abort_at) return;
    if (cyc >= 200) chk("stream_timeout", 64'(k), 8);
    if (!rnd) chk("beat_cycles", 64'(cyc), 64'(8 + stall_len));
    chk("done_pulse", done, 1);
    chk("done_valid", mem_valid, 0);
    chk("done_req_ready", req_ready, 0);
    @(posedge clk); #1;
    chk("after_done", done, 0);
    chk("after_req_ready", req_ready, 1);
    chk("after_valid", mem_valid, 0);
  endtask

  initial begin
    logic [255:0] la, lb, lr;
    logic [2:0]   w;
    logic [31:0]  a;

    vt[0] = '{3'd3, 32'h0000_1234, 16'h1111, 32'h0000_1220};
    vt[1] = '{3'd0, 32'hFFFF_FFE7, 16'h0000, 32'hFFFF_FFE0};
    vt[2] = '{3'd7, 32'h8000_001F, 16'hBEEF, 32'h8000_0000};
    vt[3] = '{3'd5, 32'h0000_0020, 16'h5A5A, 32'h0000_0020};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_way   = '0;
    req_addr  = '0;
    mem_ready = 1'b0;
    block_in  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valid", mem_valid, 0);
    chk("rst_last", mem_last, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_parity", mem_parity, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Idle with no request: nothing streams
    for (int i = 0; i < 20; i++) begin
      chk("idle_valid", mem_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_req_ready", req_ready, 1);
      @(posedge clk); #1;
    end

    // Table-driven requests, other ways filled with distractor lines
    for (int t = 0; t < 4; t++) begin
      for (int wi = 0; wi < 8; wi++) set_way(wi, make_line(16'hA000 + 16'(wi)));
      la = make_line(vt[t].hi);
      set_way(int'(vt[t].way), la);
      mem_ready = 1'b1;
      send_req(vt[t].way, vt[t].addr, 1'b0);
      stream(vt[t].exp_base, la, -1, 0, 1'b0, -1, 1'b0);
    end

    // Backpressure on beat 2 for 3 cycles: beat held stable, no duplicates
    la = make_line(16'h1111);
    set_way(3, la);
    send_req(3'd3, 32'h0000_1234, 1'b0);
    stream(32'h0000_1220, la, 2, 3, 1'b0, -1, 1'b0);

    // Request held and block_in changed during SEND: second line follows done
    la = make_line(16'hC0DE);
    lb = make_line(16'hF00D);
    set_way(2, la);
    send_req(3'd2, 32'h0000_4000, 1'b1);
    set_way(2, lb);
    stream(32'h0000_4000, la, -1, 0, 1'b0, -1, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    stream(32'h0000_4000, lb, -1, 0, 1'b0, -1, 1'b0);

    // Randomized requests with random backpressure and block_in churn
    for (int r = 0; r < 20; r++) begin
      fill_random_block();
      w  = 3'($urandom_range(0, 7));
      a  = $urandom;
      lr = block_in[int'(w)*256 +: 256];
      send_req(w, a, 1'b0);
      stream(a & 32'hFFFF_FFE0, lr, -1, 0, 1'b1, -1, 1'b1);
    end

    // Reset while beat 4 is presented: abort, no done, restart from beat 0
    la = make_line(16'h7777);
    set_way(6, la);
    send_req(3'd6, 32'h0001_0000, 1'b0);
    stream(32'h0001_0000, la, -1, 0, 1'b0, 4, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_valid", mem_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_addr", mem_addr, 0);
    chk("abort_data", mem_data, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("post_abort_done", done, 0);
      chk("post_abort_valid", mem_valid, 0);
      @(posedge clk); #1;
    end
    lb = make_line(16'h2468);
    set_way(1, lb);
    send_req(3'd1, 32'h0002_0044, 1'b0);
    stream(32'h0002_0040, lb, -1, 0, 1'b0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
